// File: rtl/clk_div_ctrl_pkg.sv
// ============================================================================
// clk_div_ctrl_pkg : shared types and the quadrature Gray successor helper.
// Revision 1.0
// ============================================================================
`default_nettype none

package clk_div_ctrl_pkg;

  typedef enum logic [2:0] {
    DRST   = 3'd0,
    SETTLE = 3'd1,
    IDLE   = 3'd2,
    GAP    = 3'd3,
    OWN    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PH0   = 2'd0,
    PH90  = 2'd1,
    PH180 = 2'd2,
    PH270 = 2'd3
  } phase_e;

  localparam int CHK_ARM_CYCLES = 2;

  // Legal next value of {clk0, clk90}: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] gray_next(input logic [1:0] cur);
    case (cur)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_ctrl_rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick, first set request above ptr.
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  int               w_sum;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    w_sum = 0;
    w_idx = '0;
    // Offset NUM_REQ wraps back onto ptr itself, so it has lowest priority.
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_sum = int'(ptr) + off;
      if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
      w_idx = PTR_W'(w_sum);
      if (!valid && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        valid        = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
// ============================================================================
// clk_div_ctrl : quadrature divider reset sequencer, phase-select arbiter and
// glitch-free phase gate. Optional lock check: CLK_DIV_CTRL_LOCK_CHECK_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DIV_RST_CYCLES = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 restart_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ*2-1:0] phase_sel_i,
  input  logic                 clk0_i,
  input  logic                 clk90_i,
  input  logic                 clk180_i,
  input  logic                 clk270_i,
  output logic                 div_rst_o,
  output logic                 ready_o,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [1:0]           phase_o,
  output logic                 phase_en_o,
  output logic                 lock_err_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 16;

  state_e             r_state, w_state;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [PTR_W-1:0]   r_ptr, w_ptr;
  logic [PTR_W-1:0]   r_win, w_win;
  phase_e             r_lat, w_lat;
  logic               r_ever, w_ever;
  logic               r_div_rst, w_div_rst;
  logic               r_ready, w_ready;
  logic [NUM_REQ-1:0] r_gnt, w_gnt;
  phase_e             r_phase, w_phase;
  logic               r_phase_en, w_phase_en;
  logic               r_lock_err;
  logic               w_lock_viol;

  logic [NUM_REQ-1:0] w_arb_gnt;
  logic               w_arb_valid;
  logic [PTR_W-1:0]   w_arb_idx;
  phase_e             w_arb_phase;
  logic [1:0]         w_sel [NUM_REQ];
  logic [NUM_REQ-1:0] w_win_oh;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_sel
    assign w_sel[g] = phase_sel_i[2*g +: 2];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req   (req_i),
    .ptr   (r_ptr),
    .grant (w_arb_gnt),
    .valid (w_arb_valid)
  );

  always_comb begin
    w_arb_idx   = '0;
    w_arb_phase = PH0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arb_gnt[i]) begin
        w_arb_idx   = PTR_W'(i);
        w_arb_phase = phase_e'(w_sel[i]);
      end
    end
  end

  assign w_win_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_win;

`ifdef CLK_DIV_CTRL_LOCK_CHECK_EN
  logic [1:0] r_q, r_q_prev, r_qn;
  logic [1:0] r_arm;
  logic       w_active;

  assign w_active = (r_state == IDLE) || (r_state == GAP) || (r_state == OWN);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_q      <= 2'b00;
      r_q_prev <= 2'b00;
      r_qn     <= 2'b11;
      r_arm    <= 2'd0;
    end else begin
      r_q      <= {clk0_i, clk90_i};
      r_qn     <= {clk180_i, clk270_i};
      r_q_prev <= r_q;
      if (!w_active) r_arm <= 2'd0;
      else if (r_arm != 2'(CHK_ARM_CYCLES)) r_arm <= r_arm + 2'd1;
    end
  end

  assign w_lock_viol = w_active && (r_arm == 2'(CHK_ARM_CYCLES)) &&
                       (((r_q != r_q_prev) && (r_q != gray_next(r_q_prev))) ||
                        (r_qn != ~r_q));
`else
  logic w_unused_clks;
  assign w_unused_clks = ^{clk0_i, clk90_i, clk180_i, clk270_i};
  assign w_lock_viol   = 1'b0;
`endif

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_ptr      = r_ptr;
    w_win      = r_win;
    w_lat      = r_lat;
    w_ever     = r_ever;
    w_div_rst  = r_div_rst;
    w_ready    = r_ready;
    w_gnt      = r_gnt;
    w_phase    = r_phase;
    w_phase_en = r_phase_en;
    if (restart_i || w_lock_viol) begin
      w_state    = DRST;
      w_cnt      = '0;
      w_ptr      = PTR_W'(NUM_REQ-1);
      w_win      = '0;
      w_lat      = PH0;
      w_ever     = 1'b0;
      w_div_rst  = 1'b0;
      w_ready    = 1'b0;
      w_gnt      = '0;
      w_phase    = PH0;
      w_phase_en = 1'b0;
    end else begin
      case (r_state)
        DRST: begin
          if (r_cnt == CNT_W'(DIV_RST_CYCLES-1)) begin
            w_state   = SETTLE;
            w_cnt     = '0;
            w_div_rst = 1'b1;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end
        SETTLE: begin
          if (r_cnt == CNT_W'(SETTLE_CYCLES-1)) begin
            w_state = IDLE;
            w_cnt   = '0;
            w_ready = 1'b1;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end
        IDLE: begin
          w_phase_en = r_ever;
          if (w_arb_valid) begin
            w_win = w_arb_idx;
            w_lat = w_arb_phase;
            if (w_arb_phase == r_phase) begin
              w_state    = OWN;
              w_gnt      = w_arb_gnt;
              w_phase_en = 1'b1;
              w_ever     = 1'b1;
            end else begin
              w_state    = GAP;
              w_cnt      = '0;
              w_phase_en = 1'b0;
            end
          end
        end
        GAP: begin
          // Owner withdrawing mid-gap aborts without touching phase_o.
          if (!req_i[r_win]) begin
            w_state    = IDLE;
            w_ptr      = r_win;
            w_cnt      = '0;
            w_phase_en = r_ever;
          end else if (r_cnt == CNT_W'(GAP_CYCLES-1)) begin
            w_state    = OWN;
            w_cnt      = '0;
            w_phase    = r_lat;
            w_gnt      = w_win_oh;
            w_phase_en = 1'b1;
            w_ever     = 1'b1;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end
        OWN: begin
          if (!req_i[r_win]) begin
            w_state = IDLE;
            w_gnt   = '0;
            w_ptr   = r_win;
          end
        end
        default: w_state = DRST;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= DRST;
      r_cnt      <= '0;
      r_ptr      <= PTR_W'(NUM_REQ-1);
      r_win      <= '0;
      r_lat      <= PH0;
      r_ever     <= 1'b0;
      r_div_rst  <= 1'b0;
      r_ready    <= 1'b0;
      r_gnt      <= '0;
      r_phase    <= PH0;
      r_phase_en <= 1'b0;
      r_lock_err <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_ptr      <= w_ptr;
      r_win      <= w_win;
      r_lat      <= w_lat;
      r_ever     <= w_ever;
      r_div_rst  <= w_div_rst;
      r_ready    <= w_ready;
      r_gnt      <= w_gnt;
      r_phase    <= w_phase;
      r_phase_en <= w_phase_en;
      r_lock_err <= r_lock_err | w_lock_viol;
    end
  end

  assign div_rst_o  = r_div_rst;
  assign ready_o    = r_ready;
  assign gnt_o      = r_gnt;
  assign phase_o    = r_phase;
  assign phase_en_o = r_phase_en;
  assign lock_err_o = r_lock_err;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
// ============================================================================
// tb_clk_div_ctrl : directed self-checking bench for clk_div_ctrl.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_clk_div_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       restart_i;
  logic [3:0] req_i;
  logic [7:0] phase_sel_i;
  logic       clk0_i, clk90_i, clk180_i, clk270_i;
  logic       div_rst_o, ready_o, phase_en_o, lock_err_o;
  logic [3:0] gnt_o;
  logic [1:0] phase_o;

  int checks = 0;
  int errors = 0;
  int n;

  clk_div_ctrl #(
    .NUM_REQ        (4),
    .DIV_RST_CYCLES (4),
    .SETTLE_CYCLES  (8),
    .GAP_CYCLES     (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .restart_i   (restart_i),
    .req_i       (req_i),
    .phase_sel_i (phase_sel_i),
    .clk0_i      (clk0_i),
    .clk90_i     (clk90_i),
    .clk180_i    (clk180_i),
    .clk270_i    (clk270_i),
    .div_rst_o   (div_rst_o),
    .ready_o     (ready_o),
    .gnt_o       (gnt_o),
    .phase_o     (phase_o),
    .phase_en_o  (phase_en_o),
    .lock_err_o  (lock_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] g, input logic [1:0] p,
                          input logic en);
    chk({tag, "_gnt"}, 32'(gnt_o), 32'(g));
    chk({tag, "_phase"}, 32'(phase_o), 32'(p));
    chk({tag, "_en"}, 32'(phase_en_o), 32'(en));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; restart_i = 1'b0; req_i = 4'b0000; phase_sel_i = 8'h00;
    clk0_i = 1'b0; clk90_i = 1'b0; clk180_i = 1'b1; clk270_i = 1'b1;

    // Reset held for three edges.
    tick(); tick(); tick();
    chk("rst_div_rst", 32'(div_rst_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_lock_err", 32'(lock_err_o), 32'd0);
    chk_outs("rst", 4'b0000, 2'd0, 1'b0);
    rst_i = 1'b1;

    n = 0;
    while (div_rst_o !== 1'b1 && n < 50) begin tick(); n++; end
    chk("drst_len", 32'(n), 32'd4);
    n = 0;
    while (ready_o !== 1'b1 && n < 50) begin tick(); n++; end
    chk("settle_len", 32'(n), 32'd8);
    chk_outs("idle0", 4'b0000, 2'd0, 1'b0);

    // Phase change 0 -> 180 for requester 0.
    req_i = 4'b0001; phase_sel_i = 8'h02;
    tick(); chk_outs("gap1", 4'b0000, 2'd0, 1'b0);
    tick(); chk_outs("gap2", 4'b0000, 2'd0, 1'b0);
    tick(); chk_outs("own0", 4'b0001, 2'd2, 1'b1);

    // Round-robin among same-phase requesters; owner's phase_sel change ignored.
    req_i = 4'b0111; phase_sel_i = 8'h2A;
    tick(); chk_outs("own0_hold", 4'b0001, 2'd2, 1'b1);
    req_i = 4'b0110;
    tick(); chk_outs("rel0", 4'b0000, 2'd2, 1'b1);
    tick(); chk_outs("own1", 4'b0010, 2'd2, 1'b1);
    req_i = 4'b0100;
    tick(); chk_outs("rel1", 4'b0000, 2'd2, 1'b1);
    tick(); chk_outs("own2", 4'b0100, 2'd2, 1'b1);

    // Requester 3 asks for 90 deg, then withdraws during the gap.
    req_i = 4'b1000; phase_sel_i = 8'h6A;
    tick(); chk_outs("rel2", 4'b0000, 2'd2, 1'b1);
    tick(); chk_outs("gap3", 4'b0000, 2'd2, 1'b0);
    req_i = 4'b0000;
    tick(); chk_outs("abort", 4'b0000, 2'd2, 1'b1);
    tick(); chk_outs("abort_idle", 4'b0000, 2'd2, 1'b1);

    // Pointer now at 3: wrap gives requester 0 priority over 1.
    req_i = 4'b0011;
    tick(); chk_outs("wrap", 4'b0001, 2'd2, 1'b1);

    // Restart while owning: full sequence replays.
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0; req_i = 4'b0000;
    chk("rs_div_rst", 32'(div_rst_o), 32'd0);
    chk("rs_ready", 32'(ready_o), 32'd0);
    chk_outs("rs", 4'b0000, 2'd0, 1'b0);
    n = 0;
    while (div_rst_o !== 1'b1 && n < 50) begin tick(); n++; end
    chk("rs_drst_len", 32'(n), 32'd4);
    n = 0;
    while (ready_o !== 1'b1 && n < 50) begin tick(); n++; end
    chk("rs_settle_len", 32'(n), 32'd8);

    // Same phase as reset value: granted one cycle later.
    req_i = 4'b0001; phase_sel_i = 8'h68;
    tick(); chk_outs("own0_b", 4'b0001, 2'd0, 1'b1);
    tick(); tick();

    // Illegal quadrature jump 00 -> 11 while owning.
    clk0_i = 1'b1; clk90_i = 1'b1; clk180_i = 1'b0; clk270_i = 1'b0;
    tick();
    chk("lock_pre", 32'(lock_err_o), 32'd0);
    tick();
`ifdef CLK_DIV_CTRL_LOCK_CHECK_EN
    chk("lock_set", 32'(lock_err_o), 32'd1);
    chk("lock_drst", 32'(div_rst_o), 32'd0);
    chk("lock_gnt", 32'(gnt_o), 32'd0);
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    chk("lock_hold", 32'(lock_err_o), 32'd1);
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    chk("lock_clr", 32'(lock_err_o), 32'd0);
`else
    chk("lock_off", 32'(lock_err_o), 32'd0);
    chk("lock_off_gnt", 32'(gnt_o), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Controller for the quadrature clock divider (outputs 0/90/180/270 deg).
- Sequences divider reset and settle after power-up or restart.
- Arbitrates NUM_REQ requesters for ownership of a single shared phase-select output.
- Gates the selected phase with an enable gap on every phase change, so downstream muxing switches glitch-free.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DIV_RST_CYCLES, 4: cycles div_rst_o is held low, >=1.
- SETTLE_CYCLES, 8: cycles after divider reset release before ready_o, >=1.
- GAP_CYCLES, 2: cycles phase_en_o is held low around a phase change, >=1.

Ports:
- clk_i  in  1  system clock; also drives the divider.
- rst_i  in  1  synchronous reset, active-low.
- restart_i  in  1  single-cycle pulse; re-runs the divider reset sequence.
- req_i  in  NUM_REQ  per-requester ownership request, level.
- phase_sel_i  in  NUM_REQ*2  requested phase per requester (0=0deg, 1=90, 2=180, 3=270).
- clk0_i, clk90_i, clk180_i, clk270_i  in  1 each  divider outputs, sampled as data in the clk_i domain.
- div_rst_o  out  1  active-low reset to the divider.
- ready_o  out  1  divider settled, arbitration open.
- gnt_o  out  NUM_REQ  one-hot grant.
- phase_o  out  2  selected phase.
- phase_en_o  out  1  phase output valid/enabled.
- lock_err_o  out  1  sticky quadrature error.

Behaviour:
- All outputs are registered.
- Reset (rst_i=0 at a clk_i edge):
  - state=DRST, counter=0, rr_ptr=NUM_REQ-1.
  - div_rst_o=0, ready_o=0, gnt_o=0, phase_o=0, phase_en_o=0, lock_err_o=0.
- DRST: div_rst_o=0 for exactly DIV_RST_CYCLES cycles, then SETTLE with div_rst_o=1.
- SETTLE: SETTLE_CYCLES cycles, then IDLE. ready_o=1 from the first IDLE cycle.
- IDLE:
  - phase_en_o=1 if a phase has ever been granted since reset, else 0.
  - If any req_i bit is set, the round-robin winner is the first set bit above rr_ptr, wrapping.
  - The winner's phase_sel_i is latched.
  - Latched phase == phase_o: go to OWN next cycle.
  - Latched phase differs: go to GAP with phase_en_o=0.
- GAP: counts GAP_CYCLES cycles. On the last cycle, phase_o takes the latched phase; the next state is OWN with phase_en_o=1.
- OWN:
  - gnt_o[w]=1 and phase_en_o=1.
  - phase_sel_i changes are ignored.
  - When req_i[w]=0: gnt_o=0 and rr_ptr=w next cycle, return to IDLE.
- Latency, req at IDLE cycle t:
  - Same phase: gnt at t+1.
  - Different phase: gnt at t+1+GAP_CYCLES.
- Winner drops req during GAP: abort to IDLE next cycle, phase_o unchanged, phase_en_o=1, rr_ptr=w.
- Non-winners are ignored until the next IDLE.
- restart_i in any state: next cycle DRST with all outputs at reset values except lock_err_o, which holds.
- rst_i has priority over restart_i.
- A requester that holds req continuously is re-granted immediately after release only if no other requester is pending.

Optional Feature:
- Macro: CLK_DIV_CTRL_LOCK_CHECK_EN.
- When defined:
  - In IDLE/GAP/OWN, a registered {clk0_i,clk90_i} must change only along 00->10->11->01->00.
  - clk180_i must equal ~clk0_i and clk270_i must equal ~clk90_i.
  - Any violation sets lock_err_o (sticky until rst_i) and forces DRST next cycle.
  - Checking is disabled in DRST/SETTLE and for the first 2 IDLE cycles.
- When undefined: clk*_i inputs are unused and lock_err_o=0 constantly.

Decomposition:
- Package clk_div_ctrl_pkg:
  - state_e {DRST, SETTLE, IDLE, GAP, OWN}.
  - phase_e {PH0, PH90, PH180, PH270}, 2-bit.
  - Gray successor function for the lock check.
- Sub-module rr_arbiter:
  - Parameterised NUM_REQ.
  - Inputs: req vector, pointer.
  - Outputs: one-hot winner, valid, combinational.

Test Plan:
- Reset, defaults: rst_i low 3 cycles then high -> div_rst_o low exactly 4 cycles, ready_o rises 8 cycles after div_rst_o rises, all other outputs 0.
- Phase change: req_i=0001 with phase 2 while phase_o=0 -> phase_en_o low 2 cycles, then phase_o=2, phase_en_o=1, gnt_o=0001.
- Same phase and round-robin: phase_o=2; req_i=0110, both requesting phase 2, after requester 0 releases -> gnt_o=0010 next cycle with no gap; after it releases -> gnt_o=0100.
- GAP abort: requester 3 asks for phase 1, drops req on the 1st GAP cycle -> IDLE, phase_o unchanged, phase_en_o=1, no grant.
- Restart in OWN: restart_i pulse -> gnt_o=0, div_rst_o=0 next cycle, full sequence replays.
- CLK_DIV_CTRL_LOCK_CHECK_EN: force {clk0_i,clk90_i} 00->11 in OWN -> lock_err_o=1 next cycle, DRST entered; lock_err_o clears only on rst_i.
